// File: rtl/seg_mux_capture.sv
// seg_mux_capture: receive side of a 2-digit multiplexed 7-segment bus.
// Synchronizes the bus, waits for {digit_sel, pattern} to hold steady, decodes
// each accepted glyph to a hex nibble and reassembles the displayed byte.
// Optional feature macro: VALID_ON_CHANGE_EN (value_valid only when the
// completed byte differs from the current value; first pair after reset always pulses).
module seg_mux_capture #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 24000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] seg_in,
  input  logic       digit_sel,
  output logic [7:0] value,
  output logic       value_valid,
  output logic       seg_err,
  output logic       stale
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam int IW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ACC  = CW'(STABLE_CYCLES - 2);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_PRE = IW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [0:0] {SEEK = 1'b0, HAVE_ONE = 1'b1} state_t;

  // Glyph gfedcba -> {is_hex, nibble}; anything else (including blank) is invalid.
  function automatic logic [4:0] decode_glyph(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'h3F:   res = {1'b1, 4'h0};
      7'h06:   res = {1'b1, 4'h1};
      7'h5B:   res = {1'b1, 4'h2};
      7'h4F:   res = {1'b1, 4'h3};
      7'h66:   res = {1'b1, 4'h4};
      7'h6D:   res = {1'b1, 4'h5};
      7'h7D:   res = {1'b1, 4'h6};
      7'h07:   res = {1'b1, 4'h7};
      7'h7F:   res = {1'b1, 4'h8};
      7'h6F:   res = {1'b1, 4'h9};
      7'h77:   res = {1'b1, 4'hA};
      7'h7C:   res = {1'b1, 4'hB};
      7'h39:   res = {1'b1, 4'hC};
      7'h5E:   res = {1'b1, 4'hD};
      7'h79:   res = {1'b1, 4'hE};
      7'h71:   res = {1'b1, 4'hF};
      default: res = 5'b0_0000;
    endcase
    return res;
  endfunction

  logic [7:0]    r_sync1, r_sync2;   // {sel, gfedcba}
  logic [7:0]    r_prev;
  logic [CW-1:0] r_cnt;
  logic          r_acc;
  logic          r_acc_sel;
  logic [4:0]    r_acc_dec;
  logic [IW-1:0] r_idle;
  logic          r_stale;
  state_t        r_state;
  logic          r_have;
  logic [3:0]    r_slot_lo, r_slot_hi;
  logic [7:0]    r_value;
  logic          r_valid;
  logic          r_err;

  logic [7:0]    w_cur;
  logic          w_change;
  logic          w_timeout;
  logic [7:0]    w_pair;
  logic          w_pair_done;
  logic          w_valid_pair;
  logic          w_unused_dp;
  state_t        w_state_nxt;
  logic          w_have_nxt;
  logic [3:0]    w_slot_lo_nxt, w_slot_hi_nxt;
  logic [7:0]    w_value_nxt;
  logic          w_valid_nxt;
  logic          w_err_nxt;

  // The decimal point carries no information for the decoded byte.
  assign w_unused_dp = seg_in[7];

  // Two-stage synchronizer for the asynchronous display bus.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 8'h00;
      r_sync2 <= 8'h00;
    end else begin
      r_sync1 <= {digit_sel, seg_in[6:0]};
      r_sync2 <= r_sync1;
    end
  end

  // Polarity is normalized after synchronization so the filter sees lit = 1.
  assign w_cur    = {r_sync2[7], (SEG_ACTIVE_LOW ? ~r_sync2[6:0] : r_sync2[6:0])};
  assign w_change = (w_cur != r_prev);

  // Stability filter: one accept per steady run, raised as cnt reaches STABLE_CYCLES-1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_prev    <= 8'h00;
      r_cnt     <= {CW{1'b0}};
      r_acc     <= 1'b0;
      r_acc_sel <= 1'b0;
      r_acc_dec <= 5'b0_0000;
    end else begin
      r_prev    <= w_cur;
      if (w_change) begin
        r_cnt <= {CW{1'b0}};
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CW'(1'b1);
      end else begin
        r_cnt <= r_cnt;
      end
      r_acc     <= !w_change && (r_cnt == CNT_ACC);
      r_acc_sel <= w_cur[7];
      r_acc_dec <= decode_glyph(w_cur[6:0]);
    end
  end

  // Idle timer since the last accept; stale is the saturated-timer flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_idle  <= {IW{1'b0}};
      r_stale <= 1'b1;
    end else if (r_acc) begin
      r_idle  <= {IW{1'b0}};
      r_stale <= 1'b0;
    end else if (r_idle != IDLE_MAX) begin
      r_idle  <= r_idle + IW'(1'b1);
      r_stale <= (r_idle == IDLE_PRE) ? 1'b1 : r_stale;
    end else begin
      r_idle  <= r_idle;
      r_stale <= r_stale;
    end
  end

  // An accept in the same cycle overrides the timeout.
  assign w_timeout   = !r_acc && (r_idle == IDLE_PRE);
  // The freshly accepted nibble fills its own slot; the partner comes from the held slot.
  assign w_pair      = {(r_acc_sel ? r_acc_dec[3:0] : r_slot_hi),
                        (r_acc_sel ? r_slot_lo : r_acc_dec[3:0])};
  assign w_pair_done = r_acc && r_acc_dec[4] && (r_state == HAVE_ONE) && (r_acc_sel != r_have);

`ifdef VALID_ON_CHANGE_EN
  logic r_first;

  // Tracks whether a pair has completed since reset so the first one always reports.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_first <= 1'b1;
    end else if (w_pair_done) begin
      r_first <= 1'b0;
    end else begin
      r_first <= r_first;
    end
  end

  assign w_valid_pair = r_first || (w_pair != r_value);
`else
  assign w_valid_pair = 1'b1;
`endif

  // Pair-assembly FSM next state and registered-output next values.
  always_comb begin
    w_state_nxt   = r_state;
    w_have_nxt    = r_have;
    w_slot_lo_nxt = r_slot_lo;
    w_slot_hi_nxt = r_slot_hi;
    w_value_nxt   = r_value;
    w_valid_nxt   = 1'b0;
    w_err_nxt     = 1'b0;
    if (r_acc && !r_acc_dec[4]) begin
      w_err_nxt   = 1'b1;
      w_state_nxt = SEEK;
    end else if (r_acc) begin
      if (r_acc_sel) begin
        w_slot_hi_nxt = r_acc_dec[3:0];
      end else begin
        w_slot_lo_nxt = r_acc_dec[3:0];
      end
      case (r_state)
        SEEK: begin
          w_have_nxt  = r_acc_sel;
          w_state_nxt = HAVE_ONE;
        end
        HAVE_ONE: begin
          if (w_pair_done) begin
            w_value_nxt = w_pair;
            w_valid_nxt = w_valid_pair;
            w_state_nxt = SEEK;
          end else begin
            w_state_nxt = HAVE_ONE;
          end
        end
        default: w_state_nxt = SEEK;
      endcase
    end else if (w_timeout && (r_state == HAVE_ONE)) begin
      w_state_nxt = SEEK;
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Pair-assembly FSM state and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= SEEK;
      r_have    <= 1'b0;
      r_slot_lo <= 4'h0;
      r_slot_hi <= 4'h0;
      r_value   <= 8'h00;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_have    <= w_have_nxt;
      r_slot_lo <= w_slot_lo_nxt;
      r_slot_hi <= w_slot_hi_nxt;
      r_value   <= w_value_nxt;
      r_valid   <= w_valid_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign value       = r_value;
  assign value_valid = r_valid;
  assign seg_err     = r_err;
  assign stale       = r_stale;

endmodule

// File: tb/tb_seg_mux_capture.sv
// Bench for seg_mux_capture: directed bus scans, a behavioural model checked
// every cycle, and literal expectations for the documented scenarios.
module tb_seg_mux_capture;

  localparam int S = 16;
  localparam int T = 24000;
`ifdef VALID_ON_CHANGE_EN
  localparam int EXP_PULSES = 2;
`else
  localparam int EXP_PULSES = 4;
`endif
  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] seg_in = 8'h6D;
  logic       digit_sel = 1'b0;
  logic [7:0] value;
  logic       value_valid, seg_err, stale;

  always #5 clk = ~clk;

  seg_mux_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .resetn(resetn), .seg_in(seg_in), .digit_sel(digit_sel),
    .value(value), .value_valid(value_valid), .seg_err(seg_err), .stale(stale)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int vv_cnt = 0, err_cnt = 0, vv_cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int glyph_index(input logic [6:0] pat);
    for (int i = 0; i < 16; i++) if (GLYPH[i] == pat) return i;
    return -1;
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct { int due; logic sel; logic [6:0] pat; } ev_t;
  ev_t        evq[$];
  int         n_edge = 0, run = 0, m_last = 0;
  logic [7:0] last_obs = 8'h00;
  logic [7:0] m_value = 8'h00;
  logic       m_vv = 1'b0, m_err = 1'b0, m_stale = 1'b1;
  bit         m_any = 1'b0, m_first = 1'b1, m_have_one = 1'b0;
  logic       m_hold_sel = 1'b0;
  logic [3:0] m_nib [2] = '{4'h0, 4'h0};

  task automatic model_accept(input logic sel, input logic [6:0] pat);
    int idx;
    logic [7:0] pair;
    idx = glyph_index(pat);
    m_any  = 1'b1;
    m_last = n_edge;
    if (idx < 0) begin
      m_err = 1'b1;
      m_have_one = 1'b0;
    end else if (!m_have_one) begin
      m_nib[sel] = 4'(idx);
      m_hold_sel = sel;
      m_have_one = 1'b1;
    end else if (sel == m_hold_sel) begin
      m_nib[sel] = 4'(idx);
    end else begin
      m_nib[sel] = 4'(idx);
      pair = {m_nib[1], m_nib[0]};
`ifdef VALID_ON_CHANGE_EN
      m_vv = m_first || (pair != m_value);
`else
      m_vv = 1'b1;
`endif
      m_first = 1'b0;
      m_value = pair;
      m_have_one = 1'b0;
    end
  endtask

  // A digit is taken once the bus has been sampled unchanged S times; its
  // effect on the outputs appears three clocks after that S-th sample.
  initial forever begin
    ev_t ev;
    logic [7:0] obs;
    bit acc;
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      evq.delete();
      n_edge = 0; run = 0; m_last = 0;
      m_value = 8'h00; m_vv = 1'b0; m_err = 1'b0; m_stale = 1'b1;
      m_any = 1'b0; m_first = 1'b1; m_have_one = 1'b0;
    end else begin
      n_edge++;
      m_vv = 1'b0; m_err = 1'b0; acc = 1'b0;
      if (evq.size() > 0 && evq[0].due == n_edge) begin
        ev = evq.pop_front();
        model_accept(ev.sel, ev.pat);
        acc = 1'b1;
      end
      obs = {digit_sel, seg_in[6:0]};
      if (run > 0 && obs == last_obs) begin
        if (run <= S) run++;
      end else begin
        run = 1;
      end
      last_obs = obs;
      if (run == S) begin
        ev.due = n_edge + 3; ev.sel = digit_sel; ev.pat = seg_in[6:0];
        evq.push_back(ev);
      end
      if (!acc && m_have_one && (n_edge - m_last == T - 1)) m_have_one = 1'b0;
      m_stale = !m_any || (n_edge - m_last >= T - 1);
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Per-cycle compare against the model, plus pulse bookkeeping from the DUT.
  initial forever begin
    @(negedge clk);
    chk("value", 32'(value), 32'(m_value));
    chk("value_valid", 32'(value_valid), 32'(m_vv));
    chk("seg_err", 32'(seg_err), 32'(m_err));
    chk("stale", 32'(stale), 32'(m_stale));
    if (value_valid === 1'b1) begin vv_cnt++; vv_cyc = cyc; end
    if (seg_err === 1'b1) err_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic hold(input logic [7:0] p, input logic s, input int n);
    seg_in = p;
    digit_sel = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    int b_vv, b_err, t_hi;
    // Reset state
    repeat (3) @(negedge clk);
    settle;
    chk("rst_value", 32'(value), 32'h00);
    chk("rst_valid", 32'(value_valid), 32'h0);
    chk("rst_err", 32'(seg_err), 32'h0);
    chk("rst_stale", 32'(stale), 32'h1);
    @(posedge clk); #2 resetn = 1'b1;

    // Scan lo=5, hi=A, 8000 clocks each
    hold(8'h6D, 1'b0, 8000);
    b_vv = vv_cnt; t_hi = cyc;
    hold(8'h77, 1'b1, 8000);
    settle;
    chk("scan_value", 32'(value), 32'hA5);
    chk("scan_pulses", 32'(vv_cnt - b_vv), 32'd1);
    chk("scan_latency", 32'(vv_cyc - t_hi), 32'd19);

    // 5-cycle glitch between the digits of 0x3C
    b_vv = vv_cnt; b_err = err_cnt;
    hold(8'h39, 1'b0, 100);
    hold(8'h7F, 1'b1, 5);
    hold(8'h4F, 1'b1, 100);
    settle;
    chk("glitch_value", 32'(value), 32'h3C);
    chk("glitch_pulses", 32'(vv_cnt - b_vv), 32'd1);
    chk("glitch_err", 32'(err_cnt - b_err), 32'd0);

    // Filter boundary: 16-cycle hold accepted, 15-cycle hold ignored
    b_vv = vv_cnt;
    hold(8'h06, 1'b0, 16);
    hold(8'h7F, 1'b1, 15);
    hold(8'h5B, 1'b1, 40);
    settle;
    chk("bound_value", 32'(value), 32'h21);
    chk("bound_pulses", 32'(vv_cnt - b_vv), 32'd1);

    // Invalid glyph on the hi digit drops the partial pair (dp set on lo: ignored)
    b_vv = vv_cnt; b_err = err_cnt;
    hold(8'hE6, 1'b0, 100);
    hold(8'h49, 1'b1, 100);
    settle;
    chk("inv_err", 32'(err_cnt - b_err), 32'd1);
    chk("inv_pulses", 32'(vv_cnt - b_vv), 32'd0);
    hold(8'h07, 1'b0, 100);
    hold(8'h7D, 1'b1, 100);
    settle;
    chk("inv_next_value", 32'(value), 32'h67);
    chk("inv_next_pulses", 32'(vv_cnt - b_vv), 32'd1);

    // hi-then-lo order, then freeze the bus
    hold(8'h7C, 1'b1, 100);
    hold(8'h5E, 1'b0, 100);
    settle;
    chk("order_value", 32'(value), 32'hBD);
    chk("fresh_stale", 32'(stale), 32'h0);
    hold(8'h5E, 1'b0, 25000);
    settle;
    chk("freeze_stale", 32'(stale), 32'h1);

    // Single digit clears stale; idling after it discards the partial pair
    hold(8'h3F, 1'b1, 40);
    settle;
    chk("clear_stale", 32'(stale), 32'h0);
    hold(8'h3F, 1'b1, 25000);
    b_vv = vv_cnt;
    hold(8'h6F, 1'b0, 100);
    settle;
    chk("timeout_no_pair", 32'(vv_cnt - b_vv), 32'd0);
    hold(8'h71, 1'b1, 100);
    settle;
    chk("timeout_value", 32'(value), 32'hF9);
    chk("timeout_pulses", 32'(vv_cnt - b_vv), 32'd1);

    // Reset after hi accepted, before lo
    hold(8'h4F, 1'b1, 100);
    @(posedge clk); #2;
    resetn = 1'b0;
    seg_in = 8'h79;
    digit_sel = 1'b0;
    b_vv = vv_cnt;
    repeat (3) @(negedge clk);
    settle;
    chk("mid_rst_value", 32'(value), 32'h00);
    chk("mid_rst_stale", 32'(stale), 32'h1);
    chk("mid_rst_pulses", 32'(vv_cnt - b_vv), 32'd0);
    @(posedge clk); #2 resetn = 1'b1;
    hold(8'h79, 1'b0, 100);
    hold(8'h06, 1'b1, 100);
    settle;
    chk("post_rst_value", 32'(value), 32'h1E);
    chk("post_rst_pulses", 32'(vv_cnt - b_vv), 32'd1);

    // 0x42 three times, then 0x43
    b_vv = vv_cnt;
    for (int k = 0; k < 3; k++) begin
      hold(8'h5B, 1'b0, 40);
      hold(8'h66, 1'b1, 40);
    end
    hold(8'h4F, 1'b0, 40);
    hold(8'h66, 1'b1, 40);
    settle;
    chk("repeat_value", 32'(value), 32'h43);
    chk("repeat_pulses", 32'(vv_cnt - b_vv), 32'(EXP_PULSES));

    repeat (30) @(negedge clk);
    settle;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
